// File: rtl/i2s_pkg.sv
// Shared constants, stereo sample type and framing helper for the I2S transmit path.
package i2s_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_CLKDIV_WIDTH = 8;
  localparam int SLOT_NUM         = 2 * DEF_DATA_WIDTH;
  localparam int SLOT_W           = $clog2(SLOT_NUM);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] left;
    logic [DEF_DATA_WIDTH-1:0] right;
  } stereo_t;

  // Word select for a slot: it flips one slot early so lrck leads the data by one sclk.
  function automatic logic lrck_for_slot(input int slot, input int slot_num);
    return ((slot + 1) % slot_num) >= (slot_num / 2);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: programmable divider, idle-time clkdiv latch and sclk register.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLKDIV_WIDTH = DEF_CLKDIV_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic [CLKDIV_WIDTH-1:0] clkdiv_i,
  output logic                    sclk_o,
  output logic                    rise_stb_o,
  output logic                    fall_stb_o
);

  logic [CLKDIV_WIDTH-1:0] div_q;
  logic [CLKDIV_WIDTH-1:0] clkdiv_lat_q;
  logic                    sclk_q;
  logic                    term_cnt;

  // Strobes flag the cycle whose closing edge toggles sclk, so consumers update in step with it.
  assign term_cnt   = en_i && (div_q == clkdiv_lat_q);
  assign rise_stb_o = term_cnt && !sclk_q;
  assign fall_stb_o = term_cnt && sclk_q;
  assign sclk_o     = sclk_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q        <= '0;
      clkdiv_lat_q <= '0;
      sclk_q       <= 1'b0;
    end else if (!en_i) begin
      div_q        <= '0;
      clkdiv_lat_q <= clkdiv_i;
      sclk_q       <= 1'b0;
    end else if (term_cnt) begin
      div_q        <= '0;
      sclk_q       <= ~sclk_q;
    end else begin
      div_q        <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_core.sv
// Philips I2S master transmitter: one-sample holding buffer, frame shifter and word-select timing.
module i2s_tx_core
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKDIV_WIDTH = DEF_CLKDIV_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic [CLKDIV_WIDTH-1:0] clkdiv_i,
  input  logic                    smp_valid_i,
  output logic                    smp_ready_o,
  input  logic [DATA_WIDTH-1:0]   smp_left_i,
  input  logic [DATA_WIDTH-1:0]   smp_right_i,
  output logic                    i2s_sclk_o,
  output logic                    i2s_lrck_o,
  output logic                    i2s_sdat_o,
  output logic                    underrun_o,
  output logic                    busy_o
);

  localparam int              SLOTS     = 2 * DATA_WIDTH;
  localparam int              SW        = $clog2(SLOTS);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOTS - 1);

  logic fall_stb;
  logic rise_stb_unused;

  i2s_clkgen #(.CLKDIV_WIDTH(CLKDIV_WIDTH)) u_clkgen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .clkdiv_i   (clkdiv_i),
    .sclk_o     (i2s_sclk_o),
    .rise_stb_o (rise_stb_unused),
    .fall_stb_o (fall_stb)
  );

  logic [SLOTS-1:0] buf_q,   buf_d;
  logic             full_q,  full_d;
  logic [SLOTS-1:0] shift_q, shift_d;
  logic [SW-1:0]    slot_q,  slot_d;
  logic             sdat_q,  sdat_d;
  logic             lrck_q,  lrck_d;
  logic             under_q, under_d;
  logic             busy_q;

  // NOTE: every variable gets a default first so this block cannot infer a latch.
  always_comb begin
    buf_d   = buf_q;
    full_d  = full_q;
    shift_d = shift_q;
    slot_d  = slot_q;
    sdat_d  = sdat_q;
    lrck_d  = lrck_q;
    under_d = 1'b0;

    // A transfer needs an empty buffer, and a load needs a full one, so they never collide.
    if (smp_valid_i && !full_q) begin
      buf_d  = {smp_left_i, smp_right_i};
      full_d = 1'b1;
    end

    if (!en_i) begin
      shift_d = '0;
      slot_d  = SLOT_LAST;
      sdat_d  = 1'b0;
      lrck_d  = 1'b0;
    end else if (fall_stb) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      lrck_d = lrck_for_slot(int'(slot_d), SLOTS);
      if (slot_d == '0) begin
        if (full_q) begin
          shift_d = {buf_q[SLOTS-2:0], 1'b0};
          sdat_d  = buf_q[SLOTS-1];
          full_d  = 1'b0;
        end else begin
          shift_d = '0;
          sdat_d  = 1'b0;
          under_d = 1'b1;
        end
      end else begin
        shift_d = {shift_q[SLOTS-2:0], 1'b0};
        sdat_d  = shift_q[SLOTS-1];
      end
    end
  end

  // NOTE: the holding buffer is reset along with its flag; a sample pending at reset is discarded.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q   <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      slot_q  <= SLOT_LAST;
      sdat_q  <= 1'b0;
      lrck_q  <= 1'b0;
      under_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      slot_q  <= slot_d;
      sdat_q  <= sdat_d;
      lrck_q  <= lrck_d;
      under_q <= under_d;
      busy_q  <= en_i;
    end
  end

  assign smp_ready_o = ~full_q;
  assign i2s_lrck_o  = lrck_q;
  assign i2s_sdat_o  = sdat_q;
  assign underrun_o  = under_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2s_tx_core.sv
// Directed bench for i2s_tx_core: decodes the serial output on sclk rising edges.
`timescale 1ns/1ps
module tb_i2s_tx_core;
  import i2s_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int CW = DEF_CLKDIV_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          en_i = 1'b0;
  logic [CW-1:0] clkdiv_i = '0;
  logic          smp_valid_i = 1'b0;
  logic          smp_ready_o;
  logic [DW-1:0] smp_left_i = '0;
  logic [DW-1:0] smp_right_i = '0;
  logic          i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, underrun_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  i2s_tx_core #(.DATA_WIDTH(DW), .CLKDIV_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .clkdiv_i(clkdiv_i),
    .smp_valid_i(smp_valid_i), .smp_ready_o(smp_ready_o),
    .smp_left_i(smp_left_i), .smp_right_i(smp_right_i),
    .i2s_sclk_o(i2s_sclk_o), .i2s_lrck_o(i2s_lrck_o), .i2s_sdat_o(i2s_sdat_o),
    .underrun_o(underrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Receiver model: on each falling clk_i edge, log sclk rises (with sdat/lrck) and underrun pulses.
  int unsigned cyc = 0;
  logic        sclk_prev = 1'b0;
  logic        rise_sd[$];
  logic        rise_lr[$];
  int unsigned rise_cyc[$];
  int unsigned ur_cyc[$];

  always @(negedge clk_i) begin
    cyc++;
    if (i2s_sclk_o && !sclk_prev) begin
      rise_sd.push_back(i2s_sdat_o);
      rise_lr.push_back(i2s_lrck_o);
      rise_cyc.push_back(cyc);
    end
    if (underrun_o) ur_cyc.push_back(cyc);
    sclk_prev = i2s_sclk_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_mon();
    rise_sd.delete();
    rise_lr.delete();
    rise_cyc.delete();
    ur_cyc.delete();
  endtask

  function automatic logic [31:0] bits_at(input int first, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (first + i < rise_sd.size()) ? rise_sd[first + i] : 1'bx};
    return v;
  endfunction

  function automatic logic [31:0] lr_at(input int first, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (first + i < rise_lr.size()) ? rise_lr[first + i] : 1'bx};
    return v;
  endfunction

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k = 0;
    while (rise_sd.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (rise_sd.size() < n) begin
      n_err++;
      $display("FAIL %s: got %0d sclk rises, expected %0d", tag, rise_sd.size(), n);
    end
  endtask

  task automatic push(input stereo_t s, input string tag);
    smp_left_i  = s.left;
    smp_right_i = s.right;
    smp_valid_i = 1'b1;
    tick();
    smp_valid_i = 1'b0;
    n_cmp++;
    if (smp_ready_o !== 1'b0) begin
      n_err++; $display("FAIL %s: ready=%b, expected 0 after accept", tag, smp_ready_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, underrun_o, busy_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b, expected 00000",
                        {i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, underrun_o, busy_o});
    end
    n_cmp++;
    if (smp_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b, expected 1", smp_ready_o);
    end
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int unsigned c_en;
    logic [31:0] w;
    clkdiv_i = 8'd1;
    tick();
    push('{left: 16'hA5C3, right: 16'h0F0F}, "basic_push");
    clear_mon();
    c_en = cyc;
    en_i = 1'b1;
    wait_rises(33, 400, "basic_rises");
    // first rise lands clkdiv+1 edges after enable, seen one negedge later
    n_cmp++;
    if (rise_cyc[0] - c_en !== 3) begin
      n_err++; $display("FAIL basic_first_rise: got %0d cycles, expected 3", rise_cyc[0] - c_en);
    end
    n_cmp++;
    if (rise_cyc[1] - rise_cyc[0] !== 4) begin
      n_err++; $display("FAIL basic_period: got %0d, expected 4", rise_cyc[1] - rise_cyc[0]);
    end
    n_cmp++;
    if ({rise_sd[0], rise_lr[0]} !== 2'b00) begin
      n_err++; $display("FAIL basic_pre_slot: got %b, expected 00", {rise_sd[0], rise_lr[0]});
    end
    w = bits_at(1, 16);
    n_cmp++;
    if (w !== 32'h0000A5C3) begin
      n_err++; $display("FAIL basic_left: got %h, expected 0000a5c3", w);
    end
    w = bits_at(17, 16);
    n_cmp++;
    if (w !== 32'h00000F0F) begin
      n_err++; $display("FAIL basic_right: got %h, expected 00000f0f", w);
    end
    w = lr_at(1, 32);
    n_cmp++;
    if (w !== 32'h0001FFFE) begin
      n_err++; $display("FAIL basic_lrck: got %h, expected 0001fffe", w);
    end
    n_cmp++;
    if (ur_cyc.size() !== 0) begin
      n_err++; $display("FAIL basic_underrun: got %0d pulses, expected 0", ur_cyc.size());
    end
    n_cmp++;
    if ({smp_ready_o, busy_o} !== 2'b11) begin
      n_err++; $display("FAIL basic_ready_busy: got %b, expected 11", {smp_ready_o, busy_o});
    end
    en_i = 1'b0;
    tick();
    n_cmp++;
    if ({i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, busy_o} !== 4'b0) begin
      n_err++; $display("FAIL basic_disable: got %b, expected 0000",
                        {i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, busy_o});
    end
  endtask

  task automatic test_underrun();
    logic [31:0] w0, w1;
    clkdiv_i = 8'd3;
    tick();
    clear_mon();
    en_i = 1'b1;
    wait_rises(66, 1200, "ur_rises");
    n_cmp++;
    if (ur_cyc.size() !== 3) begin
      n_err++; $display("FAIL ur_count: got %0d, expected 3", ur_cyc.size());
    end else begin
      n_cmp++;
      if (ur_cyc[1] - ur_cyc[0] !== 256 || ur_cyc[2] - ur_cyc[1] !== 256) begin
        n_err++; $display("FAIL ur_spacing: got %0d/%0d, expected 256/256",
                          ur_cyc[1] - ur_cyc[0], ur_cyc[2] - ur_cyc[1]);
      end
    end
    w0 = bits_at(1, 32);
    w1 = bits_at(33, 32);
    n_cmp++;
    if ({w0, w1} !== 64'h0) begin
      n_err++; $display("FAIL ur_zero_data: got %h_%h, expected 0", w0, w1);
    end
    en_i = 1'b0;
    tick();
  endtask

  task automatic test_hold_valid();
    int n = 0;
    logic [31:0] w;
    clkdiv_i = 8'd1;
    tick();
    smp_left_i = 16'h1234; smp_right_i = 16'hABCD; smp_valid_i = 1'b1;
    tick();
    smp_left_i = 16'hFEDC; smp_right_i = 16'h0001;
    tick();
    n_cmp++;
    if (smp_ready_o !== 1'b0) begin
      n_err++; $display("FAIL hold_stall: ready=%b, expected 0", smp_ready_o);
    end
    clear_mon();
    en_i = 1'b1;
    while (smp_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    // load happens on the first sclk fall: 2*(clkdiv+1) edges after enable
    n_cmp++;
    if (n !== 4) begin
      n_err++; $display("FAIL hold_ready_rise: got %0d cycles, expected 4", n);
    end
    tick();
    smp_valid_i = 1'b0;
    n_cmp++;
    if (smp_ready_o !== 1'b0) begin
      n_err++; $display("FAIL hold_second_accept: ready=%b, expected 0", smp_ready_o);
    end
    wait_rises(65, 600, "hold_rises");
    w = bits_at(1, 32);
    n_cmp++;
    if (w !== 32'h1234ABCD) begin
      n_err++; $display("FAIL hold_frame1: got %h, expected 1234abcd", w);
    end
    w = bits_at(33, 32);
    n_cmp++;
    if (w !== 32'hFEDC0001) begin
      n_err++; $display("FAIL hold_frame2: got %h, expected fedc0001", w);
    end
    n_cmp++;
    if (ur_cyc.size() !== 0) begin
      n_err++; $display("FAIL hold_underrun: got %0d pulses, expected 0", ur_cyc.size());
    end
    en_i = 1'b0;
    tick();
  endtask

  task automatic test_load_collision();
    logic [31:0] w;
    clkdiv_i = 8'd1;
    tick();
    clear_mon();
    en_i = 1'b1;
    repeat (3) tick();
    smp_left_i = 16'h8001; smp_right_i = 16'h7FFE; smp_valid_i = 1'b1;
    tick();
    smp_valid_i = 1'b0;
    n_cmp++;
    if ({underrun_o, smp_ready_o} !== 2'b10) begin
      n_err++; $display("FAIL coll_same_cycle: underrun/ready=%b, expected 10", {underrun_o, smp_ready_o});
    end
    wait_rises(65, 600, "coll_rises");
    w = bits_at(1, 32);
    n_cmp++;
    if (w !== 32'h0) begin
      n_err++; $display("FAIL coll_frame1: got %h, expected 00000000", w);
    end
    w = bits_at(33, 32);
    n_cmp++;
    if (w !== 32'h80017FFE) begin
      n_err++; $display("FAIL coll_frame2: got %h, expected 80017ffe", w);
    end
    n_cmp++;
    if (ur_cyc.size() !== 1) begin
      n_err++; $display("FAIL coll_underrun: got %0d pulses, expected 1", ur_cyc.size());
    end
    en_i = 1'b0;
    tick();
  endtask

  task automatic test_disable_midframe();
    logic [31:0] w;
    clkdiv_i = 8'd1;
    tick();
    push('{left: 16'hC0DE, right: 16'hBEEF}, "dis_push1");
    clear_mon();
    en_i = 1'b1;
    wait_rises(2, 100, "dis_load");
    push('{left: 16'h5A5A, right: 16'h3C3C}, "dis_push2");
    wait_rises(12, 100, "dis_slot10");
    en_i = 1'b0;
    tick();
    n_cmp++;
    if ({i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, busy_o, smp_ready_o} !== 5'b0) begin
      n_err++; $display("FAIL dis_idle: sclk/lrck/sdat/busy/ready=%b, expected 00000",
                        {i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, busy_o, smp_ready_o});
    end
    tick();
    clear_mon();
    en_i = 1'b1;
    wait_rises(33, 400, "dis_restart");
    n_cmp++;
    if ({rise_sd[0], rise_lr[0]} !== 2'b00) begin
      n_err++; $display("FAIL dis_pre_slot: got %b, expected 00", {rise_sd[0], rise_lr[0]});
    end
    w = bits_at(1, 32);
    n_cmp++;
    if (w !== 32'h5A5A3C3C) begin
      n_err++; $display("FAIL dis_retained: got %h, expected 5a5a3c3c", w);
    end
    w = lr_at(1, 32);
    n_cmp++;
    if (w !== 32'h0001FFFE || ur_cyc.size() !== 0) begin
      n_err++; $display("FAIL dis_framing: lrck %h ur %0d, expected 0001fffe ur 0", w, ur_cyc.size());
    end
    en_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    clkdiv_i = 8'd1;
    tick();
    push('{left: 16'hFFFF, right: 16'hFFFF}, "rst_push1");
    clear_mon();
    en_i = 1'b1;
    wait_rises(2, 100, "rst_load");
    push('{left: 16'h1111, right: 16'h2222}, "rst_push2");
    wait_rises(22, 200, "rst_slot20");
    n_cmp++;
    if ({i2s_sclk_o, i2s_lrck_o, i2s_sdat_o} !== 3'b111) begin
      n_err++; $display("FAIL rst_pre: sclk/lrck/sdat=%b, expected 111", {i2s_sclk_o, i2s_lrck_o, i2s_sdat_o});
    end
    rst_n_i = 1'b0;
    en_i = 1'b0;
    #1;
    n_cmp++;
    if ({i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, underrun_o, busy_o, smp_ready_o} !== 6'b000001) begin
      n_err++; $display("FAIL rst_async: got %b, expected 000001",
                        {i2s_sclk_o, i2s_lrck_o, i2s_sdat_o, underrun_o, busy_o, smp_ready_o});
    end
    clkdiv_i = 8'd0;
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();
    n_cmp++;
    if (smp_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_buffer_lost: ready=%b, expected 1", smp_ready_o);
    end
    clear_mon();
    en_i = 1'b1;
    wait_rises(3, 50, "rst_restart");
    n_cmp++;
    if (rise_cyc[1] - rise_cyc[0] !== 2) begin
      n_err++; $display("FAIL rst_div0_period: got %0d, expected 2", rise_cyc[1] - rise_cyc[0]);
    end
    n_cmp++;
    if (ur_cyc.size() !== 1) begin
      n_err++; $display("FAIL rst_underrun: got %0d pulses, expected 1", ur_cyc.size());
    end
    en_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_hold_valid();
    test_load_collision();
    test_disable_midframe();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
